// File: rtl/demux12_router.sv
// demux12_router: 1-to-2 demultiplexer steering each accepted word into one of two small FIFOs (a / b).
//
// Ports:
//   clk                 clock; all state updates on the rising edge
//   rst_n               asynchronous active-low reset; empties both buffers
//   i, s, in_valid      input word, route select (0 -> a, 1 -> b), input valid
//   in_ready            router accepts i this cycle (selected buffer not full)
//   a, a_valid, a_ready head of buffer a, non-empty flag, downstream consume
//   b, b_valid, b_ready head of buffer b, non-empty flag, downstream consume
//   a_cnt, b_cnt        saturating counts of words accepted into a / b
//                       (present only when DEMUX12_CNT_EN is defined)
//
// Parameters: W data width, DEPTH entries per buffer (2 or 4).
module demux12_router #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
`ifdef DEMUX12_CNT_EN
  output logic [15:0]  a_cnt,
  output logic [15:0]  b_cnt,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i,
  input  logic         s,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] a,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [W-1:0] b,
  output logic         b_valid,
  input  logic         b_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem [2][DEPTH];
  logic [PW-1:0] rp [2];
  logic [PW-1:0] wp [2];
  logic [CW-1:0] occ [2];
  logic [1:0]    full, nempty, push, pop, rdy;
  logic          acc;
  assign rdy = {b_ready, a_ready};
  assign full = {occ[1] == CW'(DEPTH), occ[0] == CW'(DEPTH)};
  assign nempty = {occ[1] != '0, occ[0] != '0};
  // Depends only on s and registered occupancy, never on the downstream readies.
  assign in_ready = ~full[s];
  assign acc = in_valid & in_ready;
  assign push = {acc & s, acc & ~s};
  assign pop = nempty & rdy;
  assign a_valid = nempty[0];
  assign b_valid = nempty[1];
  // Gate the head with non-empty so outputs read zero after reset regardless of stale memory.
  assign a = nempty[0] ? mem[0][rp[0]] : '0;
  assign b = nempty[1] ? mem[1][rp[1]] : '0;
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (push[k]) mem[k][wp[k]] <= i;
  end
  // Pointer arithmetic wraps naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        rp[k] <= '0;
        wp[k] <= '0;
        occ[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wp[k] <= wp[k] + PW'(1);
        if (pop[k]) rp[k] <= rp[k] + PW'(1);
        occ[k] <= occ[k] + CW'(push[k]) - CW'(pop[k]);
      end
    end
  end
`ifdef DEMUX12_CNT_EN
  logic [15:0] cnt [2];
  assign a_cnt = cnt[0];
  assign b_cnt = cnt[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (push[k] && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux12_router.sv
// tb_demux12_router: randomized and directed checks of demux12_router against a queue-based model.
module tb_demux12_router;
  localparam int W = 8;
  localparam int DEPTH = 2;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] i = '0;
  logic         s = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         a_valid, b_valid;
  logic         a_ready = 1'b0;
  logic         b_ready = 1'b0;
`ifdef DEMUX12_CNT_EN
  logic [15:0]  a_cnt, b_cnt;
`endif
  int total = 0;
  int bad = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int ca = 0;
  int cb = 0;

  demux12_router #(.W(W), .DEPTH(DEPTH)) dut (
`ifdef DEMUX12_CNT_EN
    .a_cnt(a_cnt), .b_cnt(b_cnt),
`endif
    .clk(clk), .rst_n(rst_n), .i(i), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".a_valid"}, 32'(a_valid), 32'(qa.size() != 0));
    check({tag, ".b_valid"}, 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) check({tag, ".a"}, 32'(a), 32'(qa[0]));
    if (qb.size() != 0) check({tag, ".b"}, 32'(b), 32'(qb[0]));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(s ? qb.size() < DEPTH : qa.size() < DEPTH));
`ifdef DEMUX12_CNT_EN
    check({tag, ".a_cnt"}, 32'(a_cnt), 32'(ca));
    check({tag, ".b_cnt"}, 32'(b_cnt), 32'(cb));
`endif
  endtask

  // Called just after a falling edge: drive, check, then advance the model across one rising edge.
  task automatic step(input logic v, input logic sel, input logic [W-1:0] d, input logic ra, input logic rb);
    logic take, pa, pb;
    in_valid = v; s = sel; i = d; a_ready = ra; b_ready = rb;
    #1;
    check_model("step");
    take = v && (sel ? qb.size() < DEPTH : qa.size() < DEPTH);
    pa = ra && qa.size() != 0;
    pb = rb && qb.size() != 0;
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (take && !sel) begin qa.push_back(d); if (ca < 65535) ca++; end
    if (take && sel) begin qb.push_back(d); if (cb < 65535) cb++; end
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".a_valid"}, 32'(a_valid), 0);
    check({tag, ".b_valid"}, 32'(b_valid), 0);
    check({tag, ".a"}, 32'(a), 0);
    check({tag, ".b"}, 32'(b), 0);
    s = 1'b0; #1;
    check({tag, ".in_ready_s0"}, 32'(in_ready), 1);
    s = 1'b1; #1;
    check({tag, ".in_ready_s1"}, 32'(in_ready), 1);
`ifdef DEMUX12_CNT_EN
    check({tag, ".a_cnt"}, 32'(a_cnt), 0);
    check({tag, ".b_cnt"}, 32'(b_cnt), 0);
`endif
  endtask

  initial begin
    #2;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;
    // Single push to a, held by a_ready=0.
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    in_valid = 1'b0; s = 1'b0; #1;
    check("first.a_valid", 32'(a_valid), 1);
    check("first.a", 32'(a), 32'h A5);
    check("first.b_valid", 32'(b_valid), 0);
    check("first.in_ready", 32'(in_ready), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    // Fill b and observe backpressure only on s=1.
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    in_valid = 1'b0; s = 1'b1; #1;
    check("fullb.b_valid", 32'(b_valid), 1);
    check("fullb.b", 32'(b), 32'h11);
    check("fullb.in_ready_s1", 32'(in_ready), 0);
    s = 1'b0; #1;
    check("fullb.in_ready_s0", 32'(in_ready), 1);
    // Full with pop at the same edge: push refused.
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    in_valid = 1'b0; s = 1'b1; #1;
    check("popfull.b", 32'(b), 32'h22);
    check("popfull.in_ready", 32'(in_ready), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    // Alternating routing with both readies high: one cycle latency per word.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k[0], 8'(k + 1), 1'b1, 1'b1);
      in_valid = 1'b0; #1;
      if (k[0]) begin
        check("alt.b_valid", 32'(b_valid), 1);
        check("alt.b", 32'(b), 32'(k + 1));
      end else begin
        check("alt.a_valid", 32'(a_valid), 1);
        check("alt.a", 32'(a), 32'(k + 1));
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    // Fill both, then reset asynchronously mid-cycle.
    while (qa.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    while (qb.size() < DEPTH) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    qa.delete(); qb.delete(); ca = 0; cb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    in_valid = 1'b0; s = 1'b0; #1;
    check("postrst.a_valid", 32'(a_valid), 1);
    check("postrst.a", 32'(a), 32'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef DEMUX12_CNT_EN
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int n = 0; n < 65537; n++) step(1'b1, 1'b0, 8'(n), 1'b1, 1'b0);
    in_valid = 1'b0; #1;
    check("sat.a_cnt", 32'(a_cnt), 32'hFFFF);
    check("sat.b_cnt", 32'(b_cnt), 1);
`endif
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
